// File: rtl/lc3_mem_arbiter.sv
// Round-robin arbiter giving the CPU datapath and the loader/debug port shared access
// to the single-port synchronous LC-3 memory, using a level req / one-cycle ack handshake.
module lc3_mem_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

  state_e     state_q;
  logic       owner_ld_q;
  logic       last_ld_q;
  logic [2:0] cnt_q;
  logic       grant_cpu;

  // CPU wins when alone, or under contention when the loader had the previous grant.
  assign grant_cpu = cpu_req & (~ld_req | last_ld_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_ld_q <= 1'b0;
      last_ld_q  <= 1'b1;
      cnt_q      <= '0;
      cpu_ack    <= 1'b0;
      ld_ack     <= 1'b0;
      cpu_rdata  <= '0;
      ld_rdata   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      ld_ack  <= 1'b0;
      mem_en  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cpu_req || ld_req) begin
            state_q    <= StAccess;
            owner_ld_q <= ~grant_cpu;
            last_ld_q  <= ~grant_cpu;
            mem_en     <= 1'b1;
            busy       <= 1'b1;
            mem_we     <= grant_cpu ? cpu_we    : ld_we;
            mem_addr   <= grant_cpu ? cpu_addr  : ld_addr;
            mem_wdata  <= grant_cpu ? cpu_wdata : ld_wdata;
          end
        end
        StAccess: begin
          if (mem_we) begin
            state_q <= StDone;
            cpu_ack <= ~owner_ld_q;
            ld_ack  <= owner_ld_q;
          end else begin
            state_q <= StWait;
            cnt_q   <= 3'(READ_LAT - 1);
          end
        end
        StWait: begin
          if (cnt_q == 3'd0) begin
            state_q <= StDone;
            cpu_ack <= ~owner_ld_q;
            ld_ack  <= owner_ld_q;
            if (owner_ld_q) ld_rdata  <= mem_rdata;
            else            cpu_rdata <= mem_rdata;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: one instance with READ_LAT=1 on a RAM model and
// one with READ_LAT=4 on a ROM model (data = addr ^ 16'h5A5A).
module tb_lc3_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ld_req, ld_we;
  logic [15:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
  logic        cpu_ack, ld_ack, mem_en, mem_we, busy;
  logic [15:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        c4_req;
  logic [15:0] c4_addr;
  logic        c4_ack, c4_ld_ack, c4_mem_en, c4_mem_we, c4_busy;
  logic [15:0] c4_rdata, c4_ld_rdata, c4_mem_addr, c4_mem_wdata, c4_mem_rdata;
  logic        zero1;
  logic [15:0] zero16;

  int checks = 0;
  int failures = 0;

  logic [15:0] ram [0:65535];
  logic [15:0] pipe4 [0:3];

  always #5 clk = ~clk;

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .cpu_req(c4_req), .cpu_we(zero1), .cpu_addr(c4_addr), .cpu_wdata(zero16),
    .cpu_ack(c4_ack), .cpu_rdata(c4_rdata),
    .ld_req(zero1), .ld_we(zero1), .ld_addr(zero16), .ld_wdata(zero16),
    .ld_ack(c4_ld_ack), .ld_rdata(c4_ld_rdata),
    .mem_en(c4_mem_en), .mem_we(c4_mem_we), .mem_addr(c4_mem_addr), .mem_wdata(c4_mem_wdata),
    .mem_rdata(c4_mem_rdata), .busy(c4_busy)
  );

  // Single-port synchronous RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  // Four-cycle-latency ROM for the READ_LAT=4 instance.
  always @(posedge clk) begin
    pipe4[0] <= c4_mem_en ? (c4_mem_addr ^ 16'h5A5A) : 16'h0000;
    pipe4[1] <= pipe4[0];
    pipe4[2] <= pipe4[1];
    pipe4[3] <= pipe4[2];
  end
  assign c4_mem_rdata = pipe4[3];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 16'(i) ^ 16'h5A5A;
    for (int i = 0; i < 4; i++) pipe4[i] = 16'h0000;
    mem_rdata = 16'h0000;
    zero1 = 1'b0; zero16 = 16'h0000;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
    c4_req = 0; c4_addr = 0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_acks", {cpu_ack, ld_ack}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata", {cpu_rdata, ld_rdata}, 0);
    chk("rst4_busy", c4_busy, 0);
    reset = 1'b0;

    // CPU write 0x3000 <- 0xBEEF
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h3000; cpu_wdata = 16'hBEEF;
    step();
    cpu_req = 0;
    chk("wr_access_en", {mem_en, mem_we}, 2'b11);
    chk("wr_access_addr", mem_addr, 16'h3000);
    chk("wr_access_data", mem_wdata, 16'hBEEF);
    chk("wr_access_busy_ack", {busy, cpu_ack}, 2'b10);
    step();
    chk("wr_done_en", mem_en, 0);
    chk("wr_done_acks", {cpu_ack, ld_ack}, 2'b10);
    chk("wr_done_busy", busy, 1);
    step();
    chk("wr_idle", {busy, cpu_ack}, 0);

    // Loader read of 0x3000
    ld_req = 1; ld_we = 0; ld_addr = 16'h3000;
    step();
    ld_req = 0;
    chk("rd_access", {mem_en, mem_we}, 2'b10);
    step();
    chk("rd_wait", {mem_en, ld_ack}, 0);
    step();
    chk("rd_done_ack", {cpu_ack, ld_ack}, 2'b01);
    chk("rd_ld_rdata", ld_rdata, 16'hBEEF);
    chk("rd_cpu_rdata_held", cpu_rdata, 16'h0000);
    step();
    chk("rd_idle", {busy, ld_ack}, 0);

    // CPU read: req dropped and addr changed after grant
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
    step();
    cpu_req = 0; cpu_addr = 16'h0000;
    step();
    chk("latch_addr", mem_addr, 16'h3000);
    step();
    chk("latch_ack", cpu_ack, 1);
    chk("latch_rdata", cpu_rdata, 16'hBEEF);
    step();
    chk("latch_ack_once_a", cpu_ack, 0);
    step();
    chk("latch_ack_once_b", {cpu_ack, busy}, 0);

    // Contention: both requests high through reset and after
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0100; cpu_wdata = 16'h1111;
    ld_req = 1; ld_we = 1; ld_addr = 16'h0200; ld_wdata = 16'h2222;
    reset = 1;
    step();
    reset = 0;
    chk("rst_req_ignored", {busy, mem_en}, 0);
    for (int k = 0; k < 12; k++) begin
      step();
      if (k % 3 == 1) begin
        chk($sformatf("rr_acks_%0d", k), {cpu_ack, ld_ack},
            ((k / 3) % 2 == 0) ? 2'b10 : 2'b01);
      end else begin
        chk($sformatf("rr_noack_%0d", k), {cpu_ack, ld_ack}, 2'b00);
      end
      if (k % 3 == 0)
        chk($sformatf("rr_addr_%0d", k), mem_addr,
            ((k / 3) % 2 == 0) ? 16'h0100 : 16'h0200);
      if (k % 3 == 2) chk($sformatf("rr_idle_%0d", k), busy, 0);
    end
    cpu_req = 0; ld_req = 0;
    step(); step();

    // Reset during ACCESS of loader write 0x4000 <- 0x1234
    ld_req = 1; ld_we = 1; ld_addr = 16'h4000; ld_wdata = 16'h1234;
    step();
    ld_req = 0;
    chk("abort_access", mem_en, 1);
    reset = 1;
    step();
    reset = 0;
    chk("abort_outs", {mem_en, mem_we, busy, cpu_ack, ld_ack}, 0);
    chk("abort_bus", {mem_addr, mem_wdata}, 0);
    chk("abort_rdata", {cpu_rdata, ld_rdata}, 0);
    step();
    chk("abort_no_ack", {ld_ack, busy}, 0);
    ld_req = 1; ld_we = 0; ld_addr = 16'h4000;
    step();
    ld_req = 0;
    step(); step();
    chk("abort_readback_ack", ld_ack, 1);
    chk("abort_readback", ld_rdata, 16'h1234);
    step();

    // READ_LAT=4 CPU read of 0x0042
    c4_req = 1; c4_addr = 16'h0042;
    step();
    c4_req = 0; c4_addr = 16'h0000;
    chk("rl4_access", c4_mem_en, 1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("rl4_wait_%0d", k), {c4_mem_en, c4_ack}, 0);
      chk($sformatf("rl4_addr_%0d", k), c4_mem_addr, 16'h0042);
    end
    step();
    chk("rl4_ack", c4_ack, 1);
    chk("rl4_rdata", c4_rdata, 16'h5A18);
    chk("rl4_addr_done", c4_mem_addr, 16'h0042);
    step();
    chk("rl4_ack_once", {c4_ack, c4_busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
# lc3_mem_arbiter

Two-port arbiter sharing the single-port synchronous LC-3 memory array between the CPU datapath (MAR/MDR side) and the program loader/debug port. Each requester uses a level request / single-cycle acknowledge handshake. Grants alternate round-robin under contention. The block drives the memory's enable, write-enable, address and write data, and returns read data to the requester that issued the read.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- READ_LAT, 1, memory read latency in cycles; legal 1..4

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, level
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse to CPU
- cpu_rdata  out  DATA_W  last CPU read data
- ld_req / ld_we / ld_addr / ld_wdata  in  1/1/ADDR_W/DATA_W  loader request, same meaning as the CPU signals
- ld_ack  out  1  one-cycle completion pulse to loader
- ld_rdata  out  DATA_W  last loader read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid READ_LAT cycles after the mem_en cycle
- busy  out  1  high whenever the FSM is not IDLE

## Operation
- FSM states:
  - IDLE: sample requests; on any request, latch the winner's we/addr/wdata and owner, go to ACCESS.
  - ACCESS: mem_en=1, mem_we=latched we, for exactly one cycle. A write goes to DONE. A read goes to WAIT.
  - WAIT: count READ_LAT cycles from the ACCESS edge. At the final edge capture mem_rdata into the owner's rdata register and go to DONE.
  - DONE: owner's ack=1 for one cycle, then return to IDLE.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting in IDLE: the requester not granted last wins.
  - The last-grant pointer resets to "loader", so the CPU wins the first contest.
- Requests are not evaluated in DONE. A req still high during its own ack cycle is treated as a new request in the following IDLE cycle.
- The request is latched at grant. Requester signals changing or req dropping after grant have no effect, and the access completes and acks anyway.
- cpu_rdata and ld_rdata are separate registers. Each updates only on its own read completion and holds otherwise. Writes never modify them.
- mem_addr, mem_wdata and mem_we are registered from the latched request and held stable from ACCESS through DONE. mem_en is high only in ACCESS.
- Reset values: state IDLE; cpu_ack, ld_ack, mem_en, mem_we, busy = 0; mem_addr, mem_wdata, cpu_rdata, ld_rdata = 0; last-grant = loader.

## Timing
- Edge 0 is the edge at which IDLE samples the request. ACCESS runs edge 0 to edge 1.
- Write: memory commits at edge 1; ack is high in the cycle after edge 1. Request-to-ack latency is 2 cycles.
- Read: mem_rdata is captured at edge 1+READ_LAT; ack is high in the following cycle with rdata already valid. Latency is 2+READ_LAT cycles.
- IDLE always lasts at least one cycle between transactions. Back-to-back throughput:
  - writes: 1 per 3 cycles
  - reads: 1 per 3+READ_LAT cycles
- At most one ack is high in any cycle, and cpu_ack and ld_ack are never high together.
- Reset mid-operation:
  - The FSM returns to IDLE and all outputs take reset values after the reset edge. No ack is issued for the aborted access.
  - If reset is sampled on the ACCESS edge, the memory also samples mem_en=1 there, so a write in flight commits and is not acked.
- Reset and req high together: the request is ignored that cycle and arbitrated in the first IDLE cycle after reset deasserts.

## Test plan
- CPU write 0x3000←0xBEEF alone → mem_en/mem_we high one cycle with addr 0x3000 and data 0xBEEF; cpu_ack 2 cycles after the sample edge; busy high for 2 cycles.
- Loader read of 0x3000 with READ_LAT=1 → ld_ack 3 cycles after the sample edge; ld_rdata=0xBEEF at ack; cpu_rdata unchanged (0x0000).
- Both requesters held high continuously right after reset → grants alternate CPU, loader, CPU, loader; never two acks in one cycle; ≥1 IDLE cycle between grants.
- CPU drops req and changes addr to 0x0000 one cycle after grant → access still uses the original address; cpu_ack still pulses once.
- Reset asserted during the ACCESS cycle of a loader write 0x4000←0x1234 → no ld_ack; all outputs 0 next cycle; a later read of 0x4000 returns 0x1234.
- READ_LAT=4 CPU read → mem_en high exactly one cycle; cpu_ack 6 cycles after the sample edge; mem_addr stable through the whole transaction.
